// File: rtl/hasti_sram_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave: response codes, transfer
// and size encodings, slave state enum and small decode helpers.
package pk_hasti;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic trans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
      default:                   trans_active = 1'b0;
    endcase
  endfunction

  // Natural alignment check; sizes wider than a word are never legal.
  function automatic logic size_legal(input logic [2:0] hsize, input logic [1:0] addr_lo);
    case (hsize)
      HSIZE_BYTE: size_legal = 1'b1;
      HSIZE_HALF: size_legal = ~addr_lo[0];
      HSIZE_WORD: size_legal = (addr_lo == 2'b00);
      default:    size_legal = 1'b0;
    endcase
  endfunction

  // Little-endian byte lanes touched by a legal transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
    case (hsize)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_mask = 4'b1111;
      default:    lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Word-wide synchronous SRAM with per-byte write enables and a one-cycle
// registered read. One read and one write may occur on the same edge; the read
// returns the word as it was before that edge's write. Contents are not reset.
module sram_1rw #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH];

  // Registered read; output holds until the next read is issued.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Byte-masked write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/hasti_sram.sv
// AHB-Lite slave in front of a word-wide SRAM. Reads are issued on the accept
// edge, writes commit on the edge that completes the data phase, and a read
// accepted on that same edge gets the completing write's bytes forwarded.
//
// Handshake: a transfer is accepted on a posedge where hsel, an active htrans
// and hready are all high; its data phase ends on the first posedge where
// hreadyout (and hence hready) is high. hready low while this slave reports
// ready means another slave is stalling the bus, so nothing advances.
module hasti_sram
  import pk_hasti::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic        hresp
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          dp_read_q, dp_write_q;
  logic [AW-1:0] wr_addr_q;
  logic [3:0]    wr_mask_q;
  logic [3:0]    fwd_mask_q;
  logic [31:0]   fwd_data_q;
  logic [31:0]   hrdata_q;
  logic [31:0]   sram_rdata;
  logic [31:0]   rd_merged;

  logic          can_accept, accept, legal, acc_ok, acc_err;
  logic          dp_done, commit, rd_issue;
  logic [AW-1:0] addr_idx;
  logic          unused_inputs;

  assign unused_inputs = ^{hburst, hprot, hmastlock, haddr[31:AW+2]};

  assign addr_idx   = haddr[AW+1:2];
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = can_accept & hsel & trans_active(htrans) & hready;
  assign legal      = size_legal(hsize, haddr[1:0]);
  assign acc_ok     = accept & legal;
  assign acc_err    = accept & ~legal;
  assign dp_done    = (state_q == ST_DATA) & hready;
  assign commit     = dp_done & dp_write_q;
  assign rd_issue   = acc_ok & ~hwrite;

  // State and wait counter register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: finish the current phase, then let a new accept override.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1:          state_d = ST_ERR2;
      ST_DATA, ST_ERR2: if (hready) state_d = ST_IDLE;
      default:          ;
    endcase
    if (acc_ok) begin
      if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = WS_INIT;
      end else begin
        state_d = ST_DATA;
      end
    end else if (acc_err) begin
      state_d = ST_ERR1;
    end
  end

  // Bus response decoded from the state.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
      end
      ST_ERR2: hresp = RESP_ERROR;
      default: ;
    endcase
  end

  // Data-phase kind and registered write address/lanes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_read_q  <= 1'b0;
      dp_write_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_mask_q  <= 4'b0000;
    end else begin
      if (accept) begin
        dp_read_q  <= rd_issue;
        dp_write_q <= acc_ok & hwrite;
      end else if (dp_done) begin
        dp_read_q  <= 1'b0;
        dp_write_q <= 1'b0;
      end
      if (acc_ok && hwrite) begin
        wr_addr_q <= addr_idx;
        wr_mask_q <= lane_mask(hsize, haddr[1:0]);
      end
    end
  end

  // Capture the bytes of a write completing on the same edge a read to its word is issued.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      fwd_mask_q <= 4'b0000;
      fwd_data_q <= 32'd0;
    end else if (rd_issue) begin
      fwd_mask_q <= (commit && (wr_addr_q == addr_idx)) ? wr_mask_q : 4'b0000;
      fwd_data_q <= hwdata;
    end
  end

  // Byte-accurate merge of array data and forwarded write data.
  always_comb begin
    rd_merged = sram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fwd_mask_q[i]) rd_merged[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

  // Hold the last read result once its data phase completes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hrdata_q <= 32'd0;
    end else if (dp_done && dp_read_q) begin
      hrdata_q <= rd_merged;
    end
  end

  assign hrdata = dp_read_q ? rd_merged : hrdata_q;

  sram_1rw #(.DEPTH(DEPTH)) u_sram (
    .clk     (hclk),
    .rd_en   (rd_issue),
    .rd_addr (addr_idx),
    .rd_data (sram_rdata),
    .wr_be   (commit ? wr_mask_q : 4'b0000),
    .wr_addr (wr_addr_q),
    .wr_data (hwdata)
  );

endmodule

// File: tb/tb_hasti_sram.sv
// Bench for hasti_sram: instance 0 has no wait states, instance 1 has two.
// A transfer-level model predicts hreadyout/hresp/hrdata every cycle; directed
// sequences add literal expectations for the key values.
module tb_hasti_sram;

  localparam int DEPTH = 256;

  logic hclk    = 1'b0;
  logic hresetn = 1'b1;

  always #5 hclk = ~hclk;

  logic        hsel_s     [2];
  logic [31:0] haddr_s    [2];
  logic        hwrite_s   [2];
  logic [2:0]  hsize_s    [2];
  logic [1:0]  htrans_s   [2];
  logic [31:0] hwdata_s   [2];
  logic        stall_s    [2];
  logic        hready_s   [2];
  logic        hreadyout_s[2];
  logic        hresp_s    [2];
  logic [31:0] hrdata_s   [2];
  logic [2:0]  hburst_c    = 3'd0;
  logic [3:0]  hprot_c     = 4'd0;
  logic        hmastlock_c = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    // Bus mux: this slave's ready, unless another slave is stalling the bus.
    assign hready_s[g] = hreadyout_s[g] & ~stall_s[g];
    hasti_sram #(.DEPTH(DEPTH), .WAIT_STATES(2 * g)) u_dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hsel      (hsel_s[g]),
      .haddr     (haddr_s[g]),
      .hwrite    (hwrite_s[g]),
      .hsize     (hsize_s[g]),
      .hburst    (hburst_c),
      .hprot     (hprot_c),
      .htrans    (htrans_s[g]),
      .hmastlock (hmastlock_c),
      .hwdata    (hwdata_s[g]),
      .hready    (hready_s[g]),
      .hreadyout (hreadyout_s[g]),
      .hrdata    (hrdata_s[g]),
      .hresp     (hresp_s[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] got=%h expected=%h at %0t", name, d, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level model ----------------
  bit [31:0]   m_mem [2][DEPTH];
  bit          m_dp  [2];
  bit          m_err [2];
  bit          m_rd  [2];
  bit          m_wr  [2];
  int          m_lo  [2];
  int          m_word[2];
  bit [3:0]    m_mask[2];
  bit [31:0]   m_hr  [2];
  logic [31:0] last_rd [2];
  int          last_acc[2];

  function automatic bit legal_of(input logic [2:0] sz, input logic [31:0] a);
    return (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
  endfunction

  function automatic bit [3:0] lanes_of(input logic [2:0] sz, input logic [31:0] a);
    int lo = int'(a % 4);
    int n  = 1 << sz;
    bit [3:0] m = 4'b0000;
    for (int b = 0; b < 4; b++) if (b >= lo && b < lo + n) m[b] = 1'b1;
    return m;
  endfunction

  // Compare process: check outputs, then advance the model to the next edge.
  always @(negedge hclk) begin
    for (int d = 0; d < 2; d++) begin
      bit exp_rdy;
      bit bus_rdy;
      if (!hresetn) begin
        m_dp[d] = 1'b0;
        m_lo[d] = 0;
        m_hr[d] = 32'd0;
      end
      exp_rdy = !(m_dp[d] && m_lo[d] > 0);
      chk("hreadyout", d, {31'd0, hreadyout_s[d]}, {31'd0, exp_rdy});
      chk("hresp", d, {31'd0, hresp_s[d]}, {31'd0, m_dp[d] && m_err[d]});
      chk("hrdata", d, hrdata_s[d], m_hr[d]);
      if (hresetn) begin
        bus_rdy = exp_rdy && !stall_s[d];
        if (m_dp[d] && m_lo[d] > 0) begin
          m_lo[d]--;
        end else if (bus_rdy) begin
          if (m_dp[d] && m_rd[d]) last_rd[d] = hrdata_s[d];
          if (m_dp[d] && m_wr[d])
            for (int b = 0; b < 4; b++)
              if (m_mask[d][b]) m_mem[d][m_word[d]][8*b +: 8] = hwdata_s[d][8*b +: 8];
          m_dp[d] = 1'b0;
          if (hsel_s[d] && htrans_s[d][1]) begin
            m_dp[d] = 1'b1;
            if (legal_of(hsize_s[d], haddr_s[d])) begin
              m_err[d]  = 1'b0;
              m_lo[d]   = 2 * d;
              m_rd[d]   = !hwrite_s[d];
              m_wr[d]   = hwrite_s[d];
              m_word[d] = int'((haddr_s[d] / 4) % DEPTH);
              m_mask[d] = lanes_of(hsize_s[d], haddr_s[d]);
              if (m_rd[d]) m_hr[d] = m_mem[d][m_word[d]];
            end else begin
              m_err[d] = 1'b1;
              m_lo[d]  = 1;
              m_rd[d]  = 1'b0;
              m_wr[d]  = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd);
    bit ok = 1'b0;
    int n  = 0;
    hsel_s[d]   = 1'b1;
    htrans_s[d] = 2'b10;
    haddr_s[d]  = a;
    hwrite_s[d] = w;
    hsize_s[d]  = sz;
    while (!ok && n < 40) begin
      @(negedge hclk);
      ok = hready_s[d];
      @(posedge hclk);
      n++;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL xfer_accept[%0d] got=timeout expected=accept addr=%h", d, a);
    end
    #1;
    last_acc[d] = cyc;
    hsel_s[d]   = 1'b0;
    htrans_s[d] = 2'b00;
    hwdata_s[d] = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic wait_ready(input int d, output int lows);
    bit ok = 1'b0;
    lows = 0;
    while (!ok && lows < 40) begin
      @(negedge hclk);
      if (hreadyout_s[d]) ok = 1'b1;
      else lows++;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_ready[%0d] got=timeout expected=hreadyout", d);
    end
    @(posedge hclk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lows;
    int t0;
    for (int d = 0; d < 2; d++) begin
      hsel_s[d] = 1'b0; haddr_s[d] = 32'd0; hwrite_s[d] = 1'b0; hsize_s[d] = 3'd0;
      htrans_s[d] = 2'b00; hwdata_s[d] = 32'd0; stall_s[d] = 1'b0; last_rd[d] = 32'd0;
    end
    #1 hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    idle(1);

    // Word write then read, no wait states.
    xfer(0, 1, 32'h2000_0010, 3'd2, 32'hDEAD_BEEF);
    idle(1);
    xfer(0, 0, 32'h2000_0010, 3'd2, 32'd0);
    idle(1);
    chk("rd_word", 0, last_rd[0], 32'hDEAD_BEEF);

    // Byte write to lane 3, then halfword write to lanes 0-1.
    xfer(0, 1, 32'h2000_0013, 3'd0, 32'hAAAA_AAAA);
    idle(1);
    xfer(0, 0, 32'h2000_0010, 3'd2, 32'd0);
    idle(1);
    chk("rd_byte", 0, last_rd[0], 32'hAAAD_BEEF);
    xfer(0, 1, 32'h2000_0010, 3'd1, 32'h1234_1234);
    idle(1);
    xfer(0, 0, 32'h2000_0010, 3'd2, 32'd0);
    idle(1);
    chk("rd_half", 0, last_rd[0], 32'hAAAD_1234);
    chk("model_mem", 0, m_mem[0][4], 32'hAAAD_1234);

    // Back-to-back write then read of the same word.
    xfer(0, 1, 32'h2000_0020, 3'd2, 32'h1122_3344);
    xfer(0, 0, 32'h2000_0020, 3'd2, 32'd0);
    idle(1);
    chk("rd_fwd_word", 0, last_rd[0], 32'h1122_3344);

    // Back-to-back byte write: only the written lane is forwarded.
    xfer(0, 1, 32'h2000_0024, 3'd2, 32'h5566_7788);
    idle(1);
    xfer(0, 1, 32'h2000_0025, 3'd0, 32'h9999_9999);
    xfer(0, 0, 32'h2000_0024, 3'd2, 32'd0);
    idle(1);
    chk("rd_fwd_byte", 0, last_rd[0], 32'h5566_9988);

    // Misaligned halfword and oversized write: two-cycle ERROR, no array update.
    xfer(0, 1, 32'h2000_0000, 3'd2, 32'hCAFE_F00D);
    idle(1);
    xfer(0, 1, 32'h2000_0001, 3'd1, 32'hFFFF_FFFF);
    chk("err1_ready", 0, {31'd0, hreadyout_s[0]}, 32'd0);
    chk("err1_resp", 0, {31'd0, hresp_s[0]}, 32'd1);
    idle(1);
    chk("err2_ready", 0, {31'd0, hreadyout_s[0]}, 32'd1);
    chk("err2_resp", 0, {31'd0, hresp_s[0]}, 32'd1);
    xfer(0, 1, 32'h2000_0000, 3'd3, 32'hFFFF_FFFF);
    chk("err1_resp_sz3", 0, {31'd0, hresp_s[0]}, 32'd1);
    idle(1);
    chk("err2_ready_sz3", 0, {31'd0, hreadyout_s[0]}, 32'd1);
    xfer(0, 0, 32'h2000_0000, 3'd2, 32'd0);
    idle(1);
    chk("rd_after_err", 0, last_rd[0], 32'hCAFE_F00D);
    xfer(0, 0, 32'h2000_0400, 3'd2, 32'd0);
    idle(1);
    chk("rd_alias", 0, last_rd[0], 32'hCAFE_F00D);

    // Two wait states.
    xfer(1, 1, 32'h2000_0004, 3'd2, 32'h0BAD_C0DE);
    wait_ready(1, lows);
    chk("wr_wait_lows", 1, lows, 32'd2);
    xfer(1, 0, 32'h2000_0004, 3'd2, 32'd0);
    wait_ready(1, lows);
    chk("rd_wait_lows", 1, lows, 32'd2);
    chk("rd_wait_data", 1, last_rd[1], 32'h0BAD_C0DE);

    // External stall of three cycles in the final data cycle delays the next accept.
    xfer(1, 0, 32'h2000_0004, 3'd2, 32'd0);
    t0 = last_acc[1];
    hsel_s[1] = 1'b1; htrans_s[1] = 2'b10; haddr_s[1] = 32'h2000_0004;
    hwrite_s[1] = 1'b0; hsize_s[1] = 3'd2;
    idle(2);
    stall_s[1] = 1'b1;
    idle(3);
    stall_s[1] = 1'b0;
    xfer(1, 0, 32'h2000_0004, 3'd2, 32'd0);
    chk("stall_accept_gap", 1, last_acc[1] - t0, 32'd6);
    wait_ready(1, lows);
    chk("stall_rd_data", 1, last_rd[1], 32'h0BAD_C0DE);

    // Reset during a write wait state drops the write.
    xfer(1, 1, 32'h2000_0008, 3'd2, 32'h1357_9BDF);
    wait_ready(1, lows);
    xfer(1, 1, 32'h2000_0008, 3'd2, 32'hFFFF_FFFF);
    hresetn = 1'b0;
    #1;
    chk("rst_ready", 1, {31'd0, hreadyout_s[1]}, 32'd1);
    chk("rst_resp", 1, {31'd0, hresp_s[1]}, 32'd0);
    chk("rst_hrdata", 1, hrdata_s[1], 32'd0);
    chk("rst_hrdata", 0, hrdata_s[0], 32'd0);
    @(posedge hclk);
    #1 hresetn = 1'b1;
    idle(1);
    xfer(1, 0, 32'h2000_0008, 3'd2, 32'd0);
    wait_ready(1, lows);
    chk("rd_after_rst", 1, last_rd[1], 32'h1357_9BDF);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
